player_physics: RTL

- Parametrised per-frame movement engine for one player, generalising the single-platform player mover.
- Adds: N platforms with swept landing, signed velocity with clamped gravity, edge-triggered jump, lives/death/respawn FSM, post-respawn invulnerability.
- Fully synchronous to Clk, advanced by a one-cycle frame_tick.
- Feeds PlayerX/PlayerY to the sprite renderer and collision logic.

---
 rtl/player_pkg.sv | 22 ++
 rtl/platform_detect.sv | 52 +++++
 rtl/player_physics.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/player_pkg.sv
// Shared types and constants for the player movement engine.
// Contents: FSM state encoding, facing-direction constants and the packed
// platform descriptor used by platform_detect.
package player_pkg;

  typedef enum logic [1:0] {
    GROUNDED,
    AIRBORNE,
    DYING,
    GAME_OVER
  } state_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef struct packed {
    logic [9:0] start_x;
    logic [9:0] end_x;
    logic [9:0] height;
  } platform_t;

endpackage

// File: rtl/platform_detect.sv
// Combinational platform query for the player mover.
// Ports:
//   centre      - sprite horizontal centre (11 bits, no wrap)
//   foot        - sprite bottom Y (11 bits, no wrap)
//   vy          - signed vertical velocity (two's complement)
//   plats       - packed array of platform descriptors
//   support     - some platform spans centre with its top exactly at foot
//   land        - some platform is crossed this frame while falling
//   land_height - top Y of the lowest-index landing platform
module platform_detect
  import player_pkg::*;
#(
  parameter int unsigned N_PLATFORMS = 4
) (
  input  logic [10:0]                       centre,
  input  logic [10:0]                       foot,
  input  logic signed [9:0]                 vy,
  input  platform_t [N_PLATFORMS-1:0]       plats,
  output logic                              support,
  output logic                              land,
  output logic [9:0]                        land_height
);

  logic [11:0] foot_reach;
  logic        spans;
  logic [10:0] top;

  // Swept window: the foot travels from foot to foot+vy this frame.
  assign foot_reach = {1'b0, foot} + {3'b000, vy[8:0]};

  always_comb begin
    support     = 1'b0;
    land        = 1'b0;
    land_height = '0;
    spans       = 1'b0;
    top         = '0;
    for (int unsigned i = 0; i < N_PLATFORMS; i++) begin
      top   = {1'b0, plats[i].height};
      spans = (centre >= {1'b0, plats[i].start_x}) &&
              (centre <= {1'b0, plats[i].end_x});
      if (spans && (foot == top))
        support = 1'b1;
      // First qualifying index is kept, so the lowest index wins.
      if (!land && spans && !vy[9] && (foot <= top) &&
          ({1'b0, top} <= foot_reach)) begin
        land        = 1'b1;
        land_height = plats[i].height;
      end
    end
  end

endmodule

// File: rtl/player_physics.sv
// Per-frame movement engine for one player: walking, jumping with clamped
// gravity, swept landing on N platforms, lives/death/respawn and
// post-respawn invulnerability. State advances on Clk edges where
// frame_tick and enable are both high.
// Ports:
//   Clk, Reset (async, active high), frame_tick, enable
//   move_left, move_right, jump (level), hit (pulse, any cycle)
//   plat_start/plat_end/plat_height - N_PLATFORMS x 10-bit, index i at [i*10 +: 10]
//   PlayerHeight, PlayerWidth       - sprite size
//   PlayerX, PlayerY, Direction, onPlatform, playerMoving,
//   Lives, game_over, invulnerable  - registered status outputs
module player_physics
  import player_pkg::*;
#(
  parameter int unsigned N_PLATFORMS    = 4,
  parameter int unsigned X_STEP         = 2,
  parameter int unsigned JUMP_VEL       = 8,
  parameter int unsigned GRAVITY        = 1,
  parameter int unsigned GRAV_DIV       = 2,
  parameter int unsigned MAX_FALL       = 6,
  parameter int unsigned X_START        = 30,
  parameter int unsigned Y_START        = 168,
  parameter int unsigned X_RESPAWN      = 30,
  parameter int unsigned Y_RESPAWN      = 75,
  parameter int unsigned X_MAX          = 639,
  parameter int unsigned Y_KILL         = 469,
  parameter int unsigned LIVES_INIT     = 3,
  parameter int unsigned RESPAWN_FRAMES = 30,
  parameter int unsigned INVULN_FRAMES  = 60
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     frame_tick,
  input  logic                     enable,
  input  logic                     move_left,
  input  logic                     move_right,
  input  logic                     jump,
  input  logic                     hit,
  input  logic [N_PLATFORMS*10-1:0] plat_start,
  input  logic [N_PLATFORMS*10-1:0] plat_end,
  input  logic [N_PLATFORMS*10-1:0] plat_height,
  input  logic [9:0]               PlayerHeight,
  input  logic [9:0]               PlayerWidth,
  output logic [9:0]               PlayerX,
  output logic [9:0]               PlayerY,
  output logic                     Direction,
  output logic                     onPlatform,
  output logic                     playerMoving,
  output logic [1:0]               Lives,
  output logic                     game_over,
  output logic                     invulnerable
);

  state_t            state, state_n;
  logic signed [9:0] vy, vy_n;
  logic [15:0]       grav_cnt, grav_cnt_n;
  logic [15:0]       dying_cnt, dying_cnt_n;
  logic [15:0]       invuln_cnt, invuln_cnt_n;
  logic              hit_latch, hit_latch_n;
  logic              jump_prev, jump_prev_n;
  logic [9:0]        x_n, y_n;
  logic              dir_n, moving_n;
  logic [1:0]        lives_n;

  logic              tick, jump_edge;
  logic signed [11:0] dx, x_sum, x_lim, y_sum;
  logic signed [10:0] vy_plus;
  logic [9:0]        x_new, y_air;
  logic signed [9:0] vy_grav;
  logic [10:0]       centre, foot;
  logic              kill;
  logic              support, land;
  logic [9:0]        land_height;
  platform_t [N_PLATFORMS-1:0] plats;

  always_comb begin
    for (int unsigned i = 0; i < N_PLATFORMS; i++) begin
      plats[i].start_x = plat_start[i*10 +: 10];
      plats[i].end_x   = plat_end[i*10 +: 10];
      plats[i].height  = plat_height[i*10 +: 10];
    end
  end

  assign tick      = frame_tick & enable;
  assign jump_edge = jump & ~jump_prev;

  // Horizontal step and clamp to [0, X_MAX - PlayerWidth].
  always_comb begin
    dx = '0;
    if (move_left && !move_right)
      dx = -$signed(12'(X_STEP));
    else if (move_right && !move_left)
      dx = $signed(12'(X_STEP));
    x_sum = $signed({2'b00, PlayerX}) + dx;
    x_lim = $signed(12'(X_MAX)) - $signed({2'b00, PlayerWidth});
    if (x_sum > x_lim)
      x_sum = x_lim;
    if (x_sum < 0)
      x_sum = '0;
    x_new = x_sum[9:0];
  end

  assign centre = {1'b0, x_new} + {2'b00, PlayerWidth[9:1]};
  assign foot   = {1'b0, PlayerY} + {1'b0, PlayerHeight};

  // Vertical integration; negative Y pins to the top of the screen.
  always_comb begin
    y_sum = $signed({2'b00, PlayerY}) + $signed({{2{vy[9]}}, vy});
    kill  = y_sum > $signed(12'(Y_KILL));
    y_air = (y_sum < 0) ? '0 : y_sum[9:0];
    vy_plus = $signed({vy[9], vy}) + $signed(11'(GRAVITY));
    vy_grav = (vy_plus > $signed(11'(MAX_FALL))) ? 10'(MAX_FALL) : vy_plus[9:0];
  end

  platform_detect #(
    .N_PLATFORMS(N_PLATFORMS)
  ) u_detect (
    .centre     (centre),
    .foot       (foot),
    .vy         (vy),
    .plats      (plats),
    .support    (support),
    .land       (land),
    .land_height(land_height)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= GROUNDED;
      PlayerX      <= 10'(X_START);
      PlayerY      <= 10'(Y_START);
      vy           <= '0;
      Direction    <= DIR_RIGHT;
      playerMoving <= 1'b0;
      Lives        <= 2'(LIVES_INIT);
      grav_cnt     <= '0;
      dying_cnt    <= '0;
      invuln_cnt   <= '0;
      hit_latch    <= 1'b0;
      jump_prev    <= 1'b0;
    end else begin
      state        <= state_n;
      PlayerX      <= x_n;
      PlayerY      <= y_n;
      vy           <= vy_n;
      Direction    <= dir_n;
      playerMoving <= moving_n;
      Lives        <= lives_n;
      grav_cnt     <= grav_cnt_n;
      dying_cnt    <= dying_cnt_n;
      invuln_cnt   <= invuln_cnt_n;
      hit_latch    <= hit_latch_n;
      jump_prev    <= jump_prev_n;
    end
  end

  always_comb begin
    state_n      = state;
    x_n          = PlayerX;
    y_n          = PlayerY;
    vy_n         = vy;
    dir_n        = Direction;
    moving_n     = playerMoving;
    lives_n      = Lives;
    grav_cnt_n   = grav_cnt;
    dying_cnt_n  = dying_cnt;
    invuln_cnt_n = invuln_cnt;
    hit_latch_n  = hit_latch;
    jump_prev_n  = jump_prev;

    // A latched hit is consumed by the tick; a hit arriving on the tick
    // cycle itself is held for the following tick.
    if (tick)
      hit_latch_n = 1'b0;
    if (hit && enable && !invulnerable)
      hit_latch_n = 1'b1;

    if (tick) begin
      jump_prev_n = jump;
      if (invuln_cnt != '0)
        invuln_cnt_n = invuln_cnt - 16'd1;

      unique case (state)
        GROUNDED, AIRBORNE: begin
          if (hit_latch || (state == AIRBORNE && kill)) begin
            vy_n        = '0;
            grav_cnt_n  = '0;
            dying_cnt_n = '0;
            moving_n    = 1'b0;
            if (Lives <= 2'd1) begin
              lives_n = '0;
              state_n = GAME_OVER;
            end else begin
              lives_n = Lives - 2'd1;
              state_n = DYING;
            end
          end else begin
            x_n      = x_new;
            moving_n = (x_new != PlayerX);
            if (dx < 0)
              dir_n = DIR_LEFT;
            else if (dx > 0)
              dir_n = DIR_RIGHT;

            if (state == GROUNDED) begin
              if (jump_edge) begin
                vy_n       = '0 - 10'(JUMP_VEL);
                grav_cnt_n = '0;
                state_n    = AIRBORNE;
                moving_n   = 1'b1;
              end else if (!support) begin
                vy_n       = '0;
                grav_cnt_n = '0;
                state_n    = AIRBORNE;
                moving_n   = 1'b1;
              end
            end else if (land) begin
              y_n        = land_height - PlayerHeight;
              vy_n       = '0;
              grav_cnt_n = '0;
              state_n    = GROUNDED;
            end else begin
              y_n      = y_air;
              moving_n = 1'b1;
              if (grav_cnt >= 16'(GRAV_DIV - 1)) begin
                grav_cnt_n = '0;
                vy_n       = vy_grav;
              end else begin
                grav_cnt_n = grav_cnt + 16'd1;
              end
            end
          end
        end

        DYING: begin
          moving_n = 1'b0;
          if (dying_cnt >= 16'(RESPAWN_FRAMES - 1)) begin
            x_n          = 10'(X_RESPAWN);
            y_n          = 10'(Y_RESPAWN);
            vy_n         = '0;
            grav_cnt_n   = '0;
            dying_cnt_n  = '0;
            invuln_cnt_n = 16'(INVULN_FRAMES);
            state_n      = AIRBORNE;
          end else begin
            dying_cnt_n = dying_cnt + 16'd1;
          end
        end

        GAME_OVER: begin
          moving_n = 1'b0;
        end

        default: state_n = GROUNDED;
      endcase
    end
  end

  assign onPlatform   = (state == GROUNDED);
  assign game_over    = (state == GAME_OVER);
  assign invulnerable = (invuln_cnt != '0);

endmodule
